div_seq: RTL

- Multi-cycle 32-bit divide sequencer feeding the HI/LO write path of the 5-stage MIPS pipeline.
- Instantiated beside the EX stage.
- Accepts a div/divu request and runs a 32-iteration restoring division. While busy it asserts a stall request to the pipeline control unit.
- The final value is presented as {remainder, quotient}; EX forwards it as hi/lo with whilo set, and it propagates through EX/MEM and MEM/WB unchanged.

---
 rtl/div_seq.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the EX stage HI/LO path; result is {remainder, quotient}.
// Optional macro DIV_BYZERO_FLAG_EN adds div_zero_o, flagging results produced by a zero divisor.
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
`ifdef DIV_BYZERO_FLAG_EN
  output logic                  div_zero_o,
`endif
  output logic                  stallreq_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_BYZERO,
    ST_ON,
    ST_END
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic                neg_quo_q, neg_quo_d;
  logic                neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                ready_q, ready_d;
  logic                div_zero_q, div_zero_d;

  logic [DATA_W:0]     shifted;
  logic                trial_ok;
  logic [DATA_W-1:0]   rem_next;
  logic [DATA_W-1:0]   quo_next;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   quo_fix;

  // One restoring step: the difference always fits in DATA_W bits when the trial succeeds,
  // because the partial remainder stays below the divisor.
  always_comb begin
    shifted  = {rem_q, quo_q[DATA_W-1]};
    trial_ok = (shifted >= {1'b0, dvs_q});
    rem_next = trial_ok ? (shifted[DATA_W-1:0] - dvs_q) : shifted[DATA_W-1:0];
    quo_next = {quo_q[DATA_W-2:0], trial_ok};
    quo_fix  = neg_quo_q ? -quo_next : quo_next;
    rem_fix  = neg_rem_q ? -rem_next : rem_next;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    div_zero_d = div_zero_q;

    case (state_q)
      ST_FREE: begin
        ready_d    = 1'b0;
        div_zero_d = 1'b0;
        if (start_i && !annul_i) begin
          cnt_d     = '0;
          rem_d     = '0;
          quo_d     = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
          dvs_d     = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
          neg_quo_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
          neg_rem_d = signed_div_i && opdata1_i[DATA_W-1];
          state_d   = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
        end
      end

      ST_BYZERO: begin
        if (annul_i) begin
          state_d = ST_FREE;
          ready_d = 1'b0;
        end else begin
          state_d    = ST_END;
          result_d   = '0;
          ready_d    = 1'b1;
          div_zero_d = 1'b1;
        end
      end

      ST_ON: begin
        if (annul_i) begin
          state_d = ST_FREE;
          ready_d = 1'b0;
        end else begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d  = ST_END;
            result_d = {rem_fix, quo_fix};
            ready_d  = 1'b1;
          end
        end
      end

      ST_END: begin
        if (annul_i || !start_i) begin
          state_d    = ST_FREE;
          ready_d    = 1'b0;
          div_zero_d = 1'b0;
        end
      end

      default: begin
        state_d    = ST_FREE;
        ready_d    = 1'b0;
        div_zero_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FREE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      div_zero_q <= div_zero_d;
    end
  end

  // Stall drops in the cycle ready rises so EX captures the result that cycle.
  assign stallreq_o = start_i & ~annul_i & ~ready_q;
  assign result_o   = result_q;
  assign ready_o    = ready_q;

`ifdef DIV_BYZERO_FLAG_EN
  assign div_zero_o = div_zero_q;
`else
  logic unused_div_zero;
  assign unused_div_zero = div_zero_q;
`endif

endmodule
